mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences and shares the single synchronous memory port between two requesters: instruction fetch (stage P1) and load/store (stage P4).
- Load/store has priority over fetch.
- The fetch stage uses ~if_grant as its stall, so the PC holds while memory is taken.
- Sits between the processor pipeline and the memory (m_addr, m_data, m_rw, m_q).

Parameters:
- READ_LAT, 1, memory read latency in cycles from address sample to valid m_q; legal range 1..4.
- ADDR_W, 12, memory address width.
- DATA_W, 16, memory data width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch wants a read this cycle.
- if_addr  in  ADDR_W  fetch address (PC).
- if_grant  out  1  combinational; fetch address is driven to memory this cycle.
- if_valid  out  1  registered; m_q holds data for a fetch granted READ_LAT cycles earlier.
- if_data  out  DATA_W  equals m_q; meaningful only when if_valid=1.
- ls_req  in  1  level; load/store pending; held until ls_done.
- ls_we  in  1  1 = store, 0 = load; stable while ls_req=1.
- ls_addr  in  ADDR_W  load/store address; stable while ls_req=1.
- ls_wdata  in  DATA_W  store data; stable while ls_req=1.
- ls_done  out  1  registered one-cycle pulse; access complete.
- ls_rdata  out  DATA_W  registered load result; valid from ls_done until the next load completes.
- m_addr  out  ADDR_W  memory address, combinational from state and inputs.
- m_data  out  DATA_W  memory write data.
- m_rw  out  1  1 = write, 0 = read.
- m_q  in  DATA_W  memory read data.

Behaviour:
- States: S_FETCH, S_WAIT, S_DONE.
- Reset values:
  - State = S_FETCH.
  - Wait counter = 0.
  - Fetch tag shift register (READ_LAT bits) = 0.
  - ls_done = 0, ls_rdata = 0, if_valid = 0.
  - Any outstanding load is discarded. A reset mid-S_WAIT produces no ls_done.
- S_FETCH:
  - If ls_req=1: issue the load/store this cycle. m_addr=ls_addr, m_rw=ls_we, m_data=ls_wdata, if_grant=0.
    - Store: next state S_DONE.
    - Load: next state S_WAIT, counter=READ_LAT.
  - Otherwise if if_req=1: if_grant=1, m_addr=if_addr, m_rw=0. Push tag 1 into the fetch shift register.
  - Otherwise: m_rw=0, m_addr=if_addr, push tag 0.
  - If ls_req and if_req are both high, ls wins and if_grant=0.
- S_WAIT:
  - if_grant=0, m_rw=0, m_addr=ls_addr. Push tag 0; earlier fetch tags keep shifting out, so in-flight fetches still return if_valid.
  - Counter decrements each cycle.
  - When the counter is 1 at the clock edge: ls_rdata <= m_q, next state S_DONE.
- S_DONE:
  - ls_done=1 for exactly this cycle.
  - Fetch arbitrated as in S_FETCH with no ls check: if_req=1 gives if_grant=1.
  - ls_req is ignored; the requester must drop it this cycle.
  - Next state S_FETCH. If ls_req is still high there, it is a new request.
- Latency:
  - Store: issue cycle t, ls_done at t+1.
  - Load: issue t, ls_done at t+1+READ_LAT.
  - Fetch: grant t, if_valid at t+READ_LAT.
- m_rw=1 only in the store issue cycle, never otherwise. This guarantees no spurious writes.
- There is exactly one memory access per cycle. Responses return in issue order.

Decomposition:
- Shared package proc_pkg: state encoding constants (S_FETCH=0, S_WAIT=1, S_DONE=2) and ADDR_W/DATA_W defaults, shared with the processor.
- One natural sub-module: lat_tag_pipe, a READ_LAT-deep 1-bit shift register with synchronous reset that produces if_valid. Everything else stays in mem_port_arbiter.

Test Plan:
- Reset then if_req=1 for 5 cycles with if_addr=0..4, memory preloaded mem[i]=16'h1000+i, READ_LAT=1 -> if_grant=1 every cycle; if_valid=1 from cycle 1; if_data=16'h1000..16'h1004 in order.
- Store: ls_req=1, ls_we=1, ls_addr=12'h020, ls_wdata=16'hBEEF while if_req=1 -> issue cycle has m_rw=1, m_addr=12'h020, if_grant=0; ls_done next cycle; then reading 12'h020 returns 16'hBEEF.
- Load, READ_LAT=2, mem[12'h030]=16'h5A5A, ls_req at t -> if_grant=0 for t..t+2; ls_done=1 at t+3; ls_rdata=16'h5A5A; fetches granted at t-2 and t-1 still return if_valid at t and t+1.
- Simultaneous if_req and ls_req at t=10 -> m_addr=ls_addr at t=10, if_grant=0; fetch granted again in the S_DONE cycle with the same if_addr.
- Reset asserted in the middle cycle of S_WAIT -> next cycle state S_FETCH, ls_done never pulses, if_valid=0, m_rw=0.
- ls_req held high through S_DONE -> exactly one ls_done per issue; a second access is issued in the following S_FETCH cycle; m_rw never 1 outside a store issue cycle.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg: shared processor definitions (memory bus widths, arbiter states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: PROC_ADDR_W / PROC_DATA_W bus defaults, CNT_W wait-counter width,
//           state_t encoding for the memory port arbiter.
package proc_pkg;

  localparam int PROC_ADDR_W = 12;
  localparam int PROC_DATA_W = 16;

  // Wide enough to hold the largest legal read latency (4).
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/lat_tag_pipe.sv
// lat_tag_pipe: 1-bit tag delay line marking which memory responses belong to fetch.
// Latency: DEPTH cycles from i_tag to o_tag.
// Backpressure: none; shifts every cycle.
// Ports: i_clock, i_reset (sync, active-high), i_tag (tag pushed this cycle),
//        o_tag (tag pushed DEPTH cycles ago).
module lat_tag_pipe #(
  parameter int DEPTH = 1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_tag,
  output logic o_tag
);

  logic [DEPTH-1:0] r_sr;

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        r_sr <= '0;
      end else begin
        r_sr <= i_tag;
      end
    end
  end else begin : g_many
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        r_sr <= '0;
      end else begin
        r_sr <= {r_sr[DEPTH-2:0], i_tag};
      end
    end
  end

  assign o_tag = r_sr[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between fetch (P1) and load/store (P4).
// Latency: fetch data READ_LAT cycles after grant; store done +1; load done +1+READ_LAT.
// Backpressure: fetch stalls on ~if_grant; load/store holds ls_req until ls_done.
// Ports: clock, reset (sync, active-high);
//        fetch side   if_req, if_addr -> if_grant, if_valid, if_data;
//        ls side      ls_req, ls_we, ls_addr, ls_wdata -> ls_done, ls_rdata;
//        memory side  m_addr, m_data, m_rw -> memory, m_q <- memory.
// READ_LAT must lie in 1..4.
module mem_port_arbiter
  import proc_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = PROC_ADDR_W,
  parameter int DATA_W   = PROC_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_grant,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_rw,
  input  logic [DATA_W-1:0] m_q
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(READ_LAT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_ls_done;
  logic              w_done_nxt;
  logic [DATA_W-1:0] r_ls_rdata;
  logic              w_capture;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_capture   = 1'b0;
    if_grant    = 1'b0;
    m_addr      = if_addr;
    m_data      = ls_wdata;
    m_rw        = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (ls_req) begin
          // Load/store wins the port; this is the only place m_rw can go high.
          m_addr = ls_addr;
          m_rw   = ls_we;
          if (ls_we) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LAT;
          end
        end else begin
          if_grant = if_req;
        end
      end

      S_WAIT: begin
        // Port idles as a harmless read of ls_addr while the load returns.
        m_addr    = ls_addr;
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_capture   = 1'b1;
        end
      end

      S_DONE: begin
        // ls_req is deliberately not looked at: the requester drops it now.
        if_grant    = if_req;
        w_state_nxt = S_FETCH;
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_cnt      <= '0;
      r_ls_done  <= 1'b0;
      r_ls_rdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ls_done <= w_done_nxt;
      if (w_capture) begin
        r_ls_rdata <= m_q;
      end
    end
  end

  // Every cycle pushes a tag; only granted fetches push a 1, so load data
  // appearing on m_q is never flagged as fetch data.
  lat_tag_pipe #(
    .DEPTH (READ_LAT)
  ) u_tag_pipe (
    .i_clock (clock),
    .i_reset (reset),
    .i_tag   (if_grant),
    .o_tag   (if_valid)
  );

  assign if_data  = m_q;
  assign ls_done  = r_ls_done;
  assign ls_rdata = r_ls_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the memory port arbiter.
// Two instances share stimulus: u_dut1 (READ_LAT=1) and u_dut2 (READ_LAT=2),
// each with its own synchronous memory model refilled on reset.
module tb_mem_port_arbiter;
  import proc_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [11:0] if_addr;
  logic        ls_req;
  logic        ls_we;
  logic [11:0] ls_addr;
  logic [15:0] ls_wdata;

  logic        if_grant1, if_valid1, ls_done1, m_rw1;
  logic [15:0] if_data1, ls_rdata1, m_data1, m_q1;
  logic [11:0] m_addr1;
  logic        if_grant2, if_valid2, ls_done2, m_rw2;
  logic [15:0] if_data2, ls_rdata2, m_data2, m_q2;
  logic [11:0] m_addr2;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.READ_LAT(1), .ADDR_W(12), .DATA_W(16)) u_dut1 (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant1),
    .if_valid(if_valid1), .if_data(if_data1),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done1), .ls_rdata(ls_rdata1),
    .m_addr(m_addr1), .m_data(m_data1), .m_rw(m_rw1), .m_q(m_q1)
  );

  mem_port_arbiter #(.READ_LAT(2), .ADDR_W(12), .DATA_W(16)) u_dut2 (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant2),
    .if_valid(if_valid2), .if_data(if_data2),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done2), .ls_rdata(ls_rdata2),
    .m_addr(m_addr2), .m_data(m_data2), .m_rw(m_rw2), .m_q(m_q2)
  );

  // Preload image: mem[i] = 0x1000 + i, except mem[0x030] = 0x5A5A.
  function automatic logic [15:0] init_val(input int i);
    logic [15:0] v;
    v = 16'h1000 + 16'(i);
    if (i == 'h030) v = 16'h5A5A;
    return v;
  endfunction

  logic [15:0] mem1 [0:4095];
  logic [15:0] mem2 [0:4095];
  logic [15:0] rd1;
  logic [15:0] rd2a, rd2b;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) mem1[i] <= init_val(i);
    end else if (m_rw1) begin
      mem1[m_addr1] <= m_data1;
    end
    rd1 <= mem1[m_addr1];
  end
  assign m_q1 = rd1;

  always @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < 4096; j++) mem2[j] <= init_val(j);
    end else if (m_rw2) begin
      mem2[m_addr2] <= m_data2;
    end
    rd2a <= mem2[m_addr2];
    rd2b <= rd2a;
  end
  assign m_q2 = rd2b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    repeat (3) @(posedge clock);
    #1;

    // ---- reset state ----
    reset = 1'b0;
    #1;
    chk("rst_if_valid1", 32'(if_valid1), 0);
    chk("rst_ls_done1",  32'(ls_done1),  0);
    chk("rst_ls_rdata1", 32'(ls_rdata1), 0);
    chk("rst_m_rw1",     32'(m_rw1),     0);
    chk("rst_state2",    32'(u_dut2.r_state), 32'(S_FETCH));

    // ---- back-to-back fetches, READ_LAT=1 ----
    for (int k = 0; k < 5; k++) begin
      cyc();
      if_req = 1'b1; if_addr = 12'(k);
      #1;
      chk("fetch_grant", 32'(if_grant1), 1);
      chk("fetch_maddr", 32'(m_addr1), k);
      if (k == 0) begin
        chk("fetch_valid0", 32'(if_valid1), 0);
      end else begin
        chk("fetch_valid", 32'(if_valid1), 1);
        chk("fetch_data",  32'(if_data1), 'h1000 + k - 1);
      end
    end
    cyc();
    if_req = 1'b0;
    #1;
    chk("fetch_valid_last", 32'(if_valid1), 1);
    chk("fetch_data_last",  32'(if_data1), 'h1004);
    cyc();
    #1;
    chk("fetch_valid_idle", 32'(if_valid1), 0);

    // ---- store with fetch competing ----
    cyc();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 12'h020; ls_wdata = 16'hBEEF;
    if_req = 1'b1; if_addr = 12'h005;
    #1;
    chk("st_m_rw",   32'(m_rw1),   1);
    chk("st_m_addr", 32'(m_addr1), 'h020);
    chk("st_m_data", 32'(m_data1), 'hBEEF);
    chk("st_grant",  32'(if_grant1), 0);
    chk("st_m_rw2",  32'(m_rw2),   1);
    cyc();
    ls_req = 1'b0; ls_we = 1'b0; if_addr = 12'h020;
    #1;
    chk("st_done",        32'(ls_done1),  1);
    chk("st_done_grant",  32'(if_grant1), 1);
    chk("st_done_maddr",  32'(m_addr1),   'h020);
    chk("st_done_m_rw",   32'(m_rw1),     0);
    chk("st_done_ivalid", 32'(if_valid1), 0);
    cyc();
    if_req = 1'b0;
    #1;
    chk("st_done_clear", 32'(ls_done1),  0);
    chk("st_rb_valid",   32'(if_valid1), 1);
    chk("st_rb_data",    32'(if_data1),  'hBEEF);
    cyc();
    cyc();

    // ---- load, READ_LAT=2, fetches in flight, simultaneous requests ----
    cyc();
    if_req = 1'b1; if_addr = 12'h040;
    #1;
    chk("ld_pre_grant_a", 32'(if_grant2), 1);
    cyc();
    if_addr = 12'h041;
    #1;
    chk("ld_pre_grant_b", 32'(if_grant2), 1);
    cyc();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 12'h030; if_addr = 12'h042;
    #1;
    chk("ld_t_grant",  32'(if_grant2), 0);
    chk("ld_t_maddr",  32'(m_addr2),   'h030);
    chk("ld_t_m_rw",   32'(m_rw2),     0);
    chk("ld_t_valid",  32'(if_valid2), 1);
    chk("ld_t_data",   32'(if_data2),  'h1040);
    cyc();
    #1;
    chk("ld_t1_grant", 32'(if_grant2), 0);
    chk("ld_t1_maddr", 32'(m_addr2),   'h030);
    chk("ld_t1_valid", 32'(if_valid2), 1);
    chk("ld_t1_data",  32'(if_data2),  'h1041);
    chk("ld_t1_done",  32'(ls_done2),  0);
    cyc();
    #1;
    chk("ld_t2_grant", 32'(if_grant2), 0);
    chk("ld_t2_valid", 32'(if_valid2), 0);
    chk("ld_t2_done",  32'(ls_done2),  0);
    chk("ld1_done",    32'(ls_done1),  1);
    chk("ld1_rdata",   32'(ls_rdata1), 'h5A5A);
    cyc();
    ls_req = 1'b0;
    #1;
    chk("ld_t3_done",  32'(ls_done2),  1);
    chk("ld_t3_rdata", 32'(ls_rdata2), 'h5A5A);
    chk("ld_t3_grant", 32'(if_grant2), 1);
    chk("ld_t3_maddr", 32'(m_addr2),   'h042);
    cyc();
    if_req = 1'b0;
    #1;
    chk("ld_t4_done",  32'(ls_done2),  0);
    chk("ld_t4_rdata", 32'(ls_rdata2), 'h5A5A);
    chk("ld_t4_valid", 32'(if_valid2), 0);
    chk("ld_t4_grant", 32'(if_grant2), 0);
    cyc();
    #1;
    chk("ld_t5_valid", 32'(if_valid2), 1);
    chk("ld_t5_data",  32'(if_data2),  'h1042);

    // ---- reset in the middle of S_WAIT ----
    cyc();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 12'h031;
    #1;
    chk("rw_issue_maddr", 32'(m_addr2), 'h031);
    cyc();
    reset = 1'b1;
    #1;
    chk("rw_in_wait", 32'(u_dut2.r_state), 32'(S_WAIT));
    cyc();
    reset = 1'b0; ls_req = 1'b0; if_req = 1'b1; if_addr = 12'h007;
    #1;
    chk("rw_state",  32'(u_dut2.r_state), 32'(S_FETCH));
    chk("rw_done",   32'(ls_done2),  0);
    chk("rw_valid",  32'(if_valid2), 0);
    chk("rw_m_rw",   32'(m_rw2),     0);
    chk("rw_grant",  32'(if_grant2), 1);
    chk("rw_rdata",  32'(ls_rdata2), 0);
    cyc();
    if_req = 1'b0;
    #1;
    chk("rw_done_a", 32'(ls_done2), 0);
    cyc();
    #1;
    chk("rw_done_b",  32'(ls_done2),  0);
    chk("rw_fvalid",  32'(if_valid2), 1);
    chk("rw_fdata",   32'(if_data2),  'h1007);

    // ---- ls_req held through S_DONE ----
    cyc();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 12'h050; ls_wdata = 16'h1111;
    #1;
    chk("hold_issue1_rw",   32'(m_rw1),    1);
    chk("hold_issue1_done", 32'(ls_done1), 0);
    cyc();
    #1;
    chk("hold_done1",      32'(ls_done1), 1);
    chk("hold_done1_rw",   32'(m_rw1),    0);
    cyc();
    #1;
    chk("hold_issue2_rw",   32'(m_rw1),    1);
    chk("hold_issue2_done", 32'(ls_done1), 0);
    chk("hold_issue2_addr", 32'(m_addr1),  'h050);
    cyc();
    ls_req = 1'b0; ls_we = 1'b0;
    #1;
    chk("hold_done2",    32'(ls_done1), 1);
    chk("hold_done2_rw", 32'(m_rw1),    0);
    cyc();
    #1;
    chk("hold_idle_done", 32'(ls_done1), 0);
    chk("hold_idle_rw",   32'(m_rw1),    0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
